// File: rtl/uart_byte_rx.sv
// uart_byte_rx: synchronised UART receiver (8N1) with a single-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fpag_uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, vld_pipe;
    logic          rxs, armed, expire;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          ld_half, ld_full, take_bit, stop_smp;
    logic          stop_ok, par_bad, deliver, accept;

    // vld_pipe marks when the chain holds real pin samples rather than reset ones,
    // so the reset value of the synchroniser can never arm the receiver.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '1;
            vld_pipe <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], fpag_uart_rx};
            vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst)
            armed <= 1'b0;
        else if (vld_pipe[SYNC_STAGES-1] && rxs)
            armed <= 1'b1;
    end

    // Expiry is the step from 1 down to 0.
    assign expire = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (armed && !rxs) state_d = S_START;
            S_START:  if (expire) state_d = rxs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (expire && idx == 3'd7) state_d = S_PARITY;
            S_PARITY: if (expire) state_d = S_STOP;
`else
            S_DATA:   if (expire && idx == 3'd7) state_d = S_STOP;
`endif
            S_STOP:   if (expire) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic take_par, par_bit;
`endif

    always_comb begin
        ld_half  = 1'b0;
        ld_full  = 1'b0;
        take_bit = 1'b0;
        stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
        take_par = 1'b0;
`endif
        case (state_q)
            S_IDLE:   ld_half = armed && !rxs;
            S_START:  ld_full = expire && !rxs;
            S_DATA:   begin
                take_bit = expire;
                ld_full  = expire;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                take_par = expire;
                ld_full  = expire;
            end
`endif
            S_STOP:   stop_smp = expire;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            if (ld_half)
                cnt <= HALF;
            else if (ld_full)
                cnt <= FULL;
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
            if (state_q == S_START && expire)
                idx <= '0;
            else if (take_bit)
                idx <= idx + 3'd1;
            if (take_bit)
                shreg[idx] <= rxs;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)           par_bit <= 1'b0;
        else if (take_par) par_bit <= rxs;
    end

    assign par_bad = ^{shreg, par_bit};

    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= stop_ok && par_bad;
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign stop_ok = stop_smp && rxs;
    assign deliver = stop_ok && !par_bad;
    assign accept  = rx_valid && rx_ready;

    // A byte arriving in the same cycle the consumer drains the register is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_smp && !rxs;
            overrun   <= 1'b0;
            if (deliver && (!rx_valid || accept)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else begin
                if (deliver) overrun  <= 1'b1;
                if (accept)  rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: stimulus pushes expected events, a monitor pops and compares.
module tb_uart_byte_rx;
    localparam int CPB    = 16;
    localparam int K_BYTE = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;
    localparam int K_OVR  = 3;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun;
    logic       prev_v = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         at;
    } exp_t;
    exp_t sb[$];

    uart_byte_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .fpag_uart_rx(rx_line),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] data, input int at);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none (cycle %0d)", kind, data, cyc);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == K_BYTE) check("rx_data", data, e.data);
            if (e.at != 0) check("event_cycle", cyc, e.at);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid && !prev_v) observe(K_BYTE, rx_data);
            if (frame_err)  observe(K_FERR, 8'h00);
            if (parity_err) observe(K_PERR, 8'h00);
            if (overrun)    observe(K_OVR, 8'h00);
            prev_v = rx_valid;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_line = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
        rx_line = 1'b1;
    endtask

    function automatic logic epar(input logic [7:0] d);
        return ^d;
    endfunction

    initial begin : stim
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        idle(5);

        // good byte with exact latency: pin falls at posedge cyc+1, valid seen at +LAT-1 after that
        expect_ev(K_BYTE, 8'hA5, cyc + LAT);
        send_frame(8'hA5, epar(8'hA5), 1'b1);
        idle(20);

        // 4-cycle glitch
        rx_line = 1'b0;
        idle(4);
        rx_line = 1'b1;
        idle(40);
        check("glitch_no_valid", rx_valid, 1'b0);

        // framing error then a good byte
        expect_ev(K_FERR, 8'h00, 0);
        send_frame(8'h3C, epar(8'h3C), 1'b0);
        idle(40);
        expect_ev(K_BYTE, 8'h55, 0);
        send_frame(8'h55, epar(8'h55), 1'b1);
        idle(20);

        // overrun with consumer stalled
        rx_ready = 1'b0;
        expect_ev(K_BYTE, 8'h11, 0);
        expect_ev(K_OVR, 8'h00, 0);
        send_frame(8'h11, epar(8'h11), 1'b1);
        send_frame(8'h22, epar(8'h22), 1'b1);
        idle(20);
        check("ovr_valid_held", rx_valid, 1'b1);
        check("ovr_data_kept", rx_data, 8'h11);
        rx_ready = 1'b1;
        @(negedge clk);
        check("ovr_accept_clears", rx_valid, 1'b0);

        // reset mid-frame with the line held low, holding register full beforehand
        rx_ready = 1'b0;
        expect_ev(K_BYTE, 8'h3C, 0);
        send_frame(8'h3C, epar(8'h3C), 1'b1);
        idle(20);
        check("rst_pre_valid", rx_valid, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_line = 1'b0;
        idle(CPB / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        idle(200);
        check("rst_low_no_frame", rx_valid, 1'b0);
        rx_line  = 1'b1;
        rx_ready = 1'b1;
        idle(10);
        expect_ev(K_BYTE, 8'hF0, 0);
        send_frame(8'hF0, epar(8'hF0), 1'b1);
        idle(20);

`ifdef UART_RX_PARITY_EN
        expect_ev(K_PERR, 8'h00, 0);
        send_frame(8'h07, 1'b0, 1'b1);
        idle(20);
        check("perr_no_valid", rx_valid, 1'b0);
        expect_ev(K_BYTE, 8'h07, 0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
